// File: rtl/jtpopeye_colmix.sv
// jtpopeye_colmix: final Popeye colour stage, layer priority plus palette PROM lookup to RGB 3-3-2
// Ports: clk/rst_n clock and async active-low reset; pxl_cen/cpu_cen clock enables;
//        CSPAL_n/DD CPU palette-bank write; BAKC/txt_pxl/obj_pxl layer pixels;
//        LHBL/LVBL blanking in; prog_* PROM download; red/green/blue colour out;
//        LHBL_dly/LVBL_dly blanking aligned with the colour outputs.
module jtpopeye_colmix (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       cpu_cen,
    input  logic       CSPAL_n,
    input  logic [7:0] DD,
    input  logic [3:0] BAKC,
    input  logic [3:0] txt_pxl,
    input  logic [3:0] obj_pxl,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       prog_en,
    input  logic       prog_we,
    input  logic [6:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);
    logic       pal_bank;
    logic [7:0] bg_rom [0:31];
    logic [7:0] fg_rom [0:63];
    logic [4:0] bg_a1, bg_ra;
    logic [5:0] fg_a1, fg_ra;
    logic       fg1, lhbl1, lvbl1;
    logic [7:0] bg_q, fg_q, col;
    logic       txt_on, obj_on;
    logic [3:0] pix;

    assign txt_on = txt_pxl != 4'd0;
    assign obj_on = obj_pxl != 4'd0;
    assign pix    = txt_on ? txt_pxl : obj_pxl;
    // During download the PROMs are addressed straight from the download port.
    assign bg_ra  = prog_en ? prog_addr[4:0] : bg_a1;
    assign fg_ra  = prog_en ? prog_addr[5:0] : fg_a1;
    assign {blue, green, red} = col;

    always_ff @(posedge clk) begin
        if (prog_en && prog_we && prog_addr[6:5] == 2'b00) bg_rom[bg_ra] <= prog_data;
        if (prog_en && prog_we && prog_addr[6]) fg_rom[fg_ra] <= prog_data;
        bg_q <= bg_rom[bg_ra];
        fg_q <= fg_rom[fg_ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_bank <= 1'b0;
            bg_a1    <= '0;
            fg_a1    <= '0;
            fg1      <= 1'b0;
            lhbl1    <= 1'b0;
            lvbl1    <= 1'b0;
            col      <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else begin
            if (cpu_cen && !CSPAL_n) pal_bank <= DD[0];
            if (pxl_cen) begin
                // Stage 1 latches the address, so a bank write never tears a pixel.
                bg_a1    <= {pal_bank, BAKC};
                fg_a1    <= {!txt_on, pal_bank, pix};
                fg1      <= txt_on || obj_on;
                lhbl1    <= LHBL;
                lvbl1    <= LVBL;
                // Stage 2 relies on PROM data read on the clk after stage 1.
                col      <= (lhbl1 && lvbl1 && !prog_en) ? (fg1 ? fg_q : bg_q) : 8'd0;
                LHBL_dly <= lhbl1;
                LVBL_dly <= lvbl1;
            end
        end
    end
endmodule

// File: tb/tb_jtpopeye_colmix.sv
module tb_jtpopeye_colmix;
    logic       clk = 0, rst_n, pxl_cen, cpu_cen, CSPAL_n;
    logic [7:0] DD;
    logic [3:0] BAKC, txt_pxl, obj_pxl;
    logic       LHBL, LVBL, prog_en, prog_we;
    logic [6:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       LHBL_dly, LVBL_dly;
    int tests = 0, fails = 0;

    jtpopeye_colmix dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen), .CSPAL_n(CSPAL_n),
        .DD(DD), .BAKC(BAKC), .txt_pxl(txt_pxl), .obj_pxl(obj_pxl), .LHBL(LHBL), .LVBL(LVBL),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bgv(input int i);
        return i == 5 ? 8'hA7 : 8'(i * 37 + 11);
    endfunction

    function automatic logic [7:0] fgv(input int j);
        return j == 3 ? 8'h11 : j == 'h29 ? 8'hFF : 8'(j * 53 + 7);
    endfunction

    task automatic pxl();
        @(negedge clk); pxl_cen = 1;
        @(negedge clk); pxl_cen = 0;
    endtask

    task automatic set_bank(input logic b);
        @(negedge clk); cpu_cen = 1; CSPAL_n = 0; DD = {7'd0, b};
        @(negedge clk); cpu_cen = 0; CSPAL_n = 1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk); prog_en = 1; prog_addr = a; prog_data = d; prog_we = 1; pxl_cen = 1;
        @(negedge clk); prog_we = 0; pxl_cen = 0;
        tests++;
        if ({blue, green, red} !== 8'd0) begin
            fails++; $display("FAIL dl_black addr %h got %h want 00", a, {blue, green, red});
        end
    endtask

    task automatic test_reset();
        repeat (3) pxl();
        tests++;
        if ({blue, green, red, LHBL_dly, LVBL_dly} !== 10'd0) begin
            fails++; $display("FAIL reset_out got %b want 0", {blue, green, red, LHBL_dly, LVBL_dly});
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_download();
        for (int i = 0; i < 32; i++) wr(7'(i), bgv(i));
        for (int j = 0; j < 64; j++) wr(7'(j + 'h40), fgv(j));
        wr(7'h25, 8'h5A);
        @(negedge clk); prog_en = 0;
    endtask

    task automatic test_bg();
        txt_pxl = 0; obj_pxl = 0; BAKC = 5;
        pxl(); pxl();
        tests++;
        if ({red, green, blue} !== {3'd7, 3'd4, 2'd2}) begin
            fails++; $display("FAIL bg_a7 got r%0d g%0d b%0d want r7 g4 b2", red, green, blue);
        end
        tests++;
        if ({LHBL_dly, LVBL_dly} !== 2'b11) begin
            fails++; $display("FAIL bg_blank_dly got %b want 11", {LHBL_dly, LVBL_dly});
        end
    endtask

    task automatic test_priority();
        txt_pxl = 3; obj_pxl = 9;
        pxl(); pxl();
        tests++;
        if ({blue, green, red} !== 8'h11) begin
            fails++; $display("FAIL prio_txt got %h want 11", {blue, green, red});
        end
        txt_pxl = 0;
        pxl(); pxl();
        tests++;
        if ({blue, green, red} !== 8'hFF) begin
            fails++; $display("FAIL prio_obj got %h want ff", {blue, green, red});
        end
        obj_pxl = 0; BAKC = 5;
        pxl(); pxl();
        tests++;
        if ({blue, green, red} !== 8'hA7) begin
            fails++; $display("FAIL prio_bg got %h want a7", {blue, green, red});
        end
    endtask

    task automatic test_bank();
        BAKC = 5;
        set_bank(1);
        pxl(); pxl();
        tests++;
        if ({blue, green, red} !== bgv('h15)) begin
            fails++; $display("FAIL bank1 got %h want %h", {blue, green, red}, bgv('h15));
        end
        set_bank(0);
        pxl(); pxl();
        tests++;
        if ({blue, green, red} !== 8'hA7) begin
            fails++; $display("FAIL bank0 got %h want a7", {blue, green, red});
        end
        // bank write on the same edge as a pixel sample: that pixel keeps the old bank
        @(negedge clk); pxl_cen = 1; cpu_cen = 1; CSPAL_n = 0; DD = 8'h01;
        @(negedge clk); pxl_cen = 0; cpu_cen = 0; CSPAL_n = 1;
        pxl();
        tests++;
        if ({blue, green, red} !== 8'hA7) begin
            fails++; $display("FAIL bank_same_edge got %h want a7", {blue, green, red});
        end
        pxl();
        tests++;
        if ({blue, green, red} !== bgv('h15)) begin
            fails++; $display("FAIL bank_next_pixel got %h want %h", {blue, green, red}, bgv('h15));
        end
        set_bank(0);
        pxl(); pxl();
    endtask

    task automatic test_blank();
        BAKC = 5; txt_pxl = 0; obj_pxl = 0; LVBL = 1;
        pxl(); pxl();
        for (int k = 0; k < 6; k++) begin
            LVBL = (k == 2) ? 1'b0 : 1'b1;
            pxl();
            if (k >= 1) begin
                tests++;
                if ({blue, green, red} !== ((k == 3) ? 8'h00 : 8'hA7)) begin
                    fails++; $display("FAIL vblank_col k%0d got %h", k, {blue, green, red});
                end
                tests++;
                if (LVBL_dly !== (k != 3)) begin
                    fails++; $display("FAIL vblank_dly k%0d got %b want %b", k, LVBL_dly, k != 3);
                end
            end
        end
        LVBL = 1;
    endtask

    task automatic test_readback();
        txt_pxl = 0; obj_pxl = 0;
        for (int i = 0; i < 32; i++) begin
            set_bank(i[4]); BAKC = 4'(i);
            pxl(); pxl();
            tests++;
            if ({blue, green, red} !== bgv(i)) begin
                fails++; $display("FAIL rb_bg %h got %h want %h", i, {blue, green, red}, bgv(i));
            end
        end
        for (int j = 0; j < 64; j++) begin
            if (j[3:0] != 4'd0) begin
                set_bank(j[4]);
                txt_pxl = j[5] ? 4'd0 : 4'(j);
                obj_pxl = j[5] ? 4'(j) : 4'hF;
                pxl(); pxl();
                tests++;
                if ({blue, green, red} !== fgv(j)) begin
                    fails++; $display("FAIL rb_fg %h got %h want %h", j, {blue, green, red}, fgv(j));
                end
            end
        end
        txt_pxl = 0; obj_pxl = 0;
        set_bank(0);
    endtask

    task automatic test_async_reset();
        BAKC = 5;
        set_bank(1);
        pxl(); pxl();
        @(negedge clk); #2 rst_n = 0; #1;
        tests++;
        if ({blue, green, red, LHBL_dly, LVBL_dly} !== 10'd0) begin
            fails++; $display("FAIL async_rst got %b want 0", {blue, green, red, LHBL_dly, LVBL_dly});
        end
        @(negedge clk); rst_n = 1;
        pxl();
        tests++;
        if ({blue, green, red} !== 8'h00) begin
            fails++; $display("FAIL rst_first_pxl got %h want 00", {blue, green, red});
        end
        pxl();
        tests++;
        if ({blue, green, red} !== 8'hA7) begin
            fails++; $display("FAIL rst_second_pxl got %h want a7", {blue, green, red});
        end
    endtask

    initial begin
        rst_n = 0; pxl_cen = 0; cpu_cen = 0; CSPAL_n = 1; DD = 0; BAKC = 0;
        txt_pxl = 0; obj_pxl = 0; LHBL = 1; LVBL = 1;
        prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        test_reset();
        test_download();
        test_bg();
        test_priority();
        test_bank();
        test_blank();
        test_readback();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
